life_sequencer: RTL and testbench
=================================

Name: life_sequencer

Overview:
- Sequences one Game-of-Life generation over a double-banked 1-bit cell memory: reads current bank, writes next bank.
- Drives the VGA adapter plot interface (x, y, colour, plot) only for cells whose state changes.
- Also services user cell loads and full-grid clears between generations.
- Sits between user controls (KEY/SW decode) and the cell RAM plus vga_adapter in main.

Parameters:
- WIDTH, 160, grid columns; x range 0..WIDTH-1.
- HEIGHT, 120, grid rows; y range 0..HEIGHT-1.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse in IDLE: run exactly one generation
- run  in  1  level: while high, generations repeat back-to-back
- load  in  1  pulse in IDLE: set cell (load_x, load_y) alive
- load_x  in  8  load column
- load_y  in  7  load row
- clear  in  1  pulse in IDLE: kill every cell in current bank
- rd_en  out  1  cell read strobe
- rd_x, rd_y, rd_bank  out  8/7/1  read address
- rd_data  in  1  cell value, valid exactly 1 cycle after rd_en
- wr_en  out  1  cell write strobe
- wr_x, wr_y, wr_bank  out  8/7/1  write address
- wr_data  out  1  cell value written
- x, y  out  8/7  VGA pixel coordinate
- colour  out  3  3'b111 alive, 3'b000 dead
- plot  out  1  one-cycle VGA write strobe
- busy  out  1  high in any state but IDLE
- gen_done  out  1  one-cycle pulse at end of each generation
- generation  out  16  completed-generation count, wraps 65535->0

Behaviour:
- Reset (async): state IDLE; cur_bank=0; generation=0; all strobes, x, y, colour, addresses, gen_done at 0. Memory contents untouched.
- Mid-operation reset aborts immediately; no further reads, writes or plots; bank does not toggle.
- IDLE priority: clear > load > (start | run). Requests outside IDLE are ignored, not queued.
- LOAD (1 cycle):
  - in-range coordinate: wr_en=1 to cur_bank with wr_data=1; plot=1, colour=3'b111, x=load_x, y=load_y; return to IDLE.
  - load_x>=WIDTH or load_y>=HEIGHT: no write, no plot.
- CLEAR: one cell per cycle, raster order (x inner, y outer). Writes 0 to cur_bank and plots colour 0 at each cell. WIDTH*HEIGHT cycles; then IDLE. cur_bank and generation unchanged.
- Generation, per cell (cx, cy), raster order:
  - FETCH: 9 cycles, slot k=0..8, dy=k/3-1, dx=k%3-1; slot 4 is the cell itself.
    - In-bounds slot: rd_en=1 from cur_bank.
    - Out-of-bounds slot: rd_en=0 and contributes 0. No wrap-around; edges are dead.
  - Neighbour count: rd_data accumulated one cycle after each read into a 4-bit count of 0..8, excluding slot 4, which is captured as self.
  - EVAL: 1 cycle; last rd_data absorbed.
    - next = (count==3) | (self & count==2).
  - WRITE: 1 cycle. wr_en=1, wr_bank=~cur_bank, wr_data=next, written for every cell.
    - If next != self: plot=1, x=cx, y=cy, colour = next ? 3'b111 : 3'b000.
  - Total: fixed 11 cycles per cell; full generation = 11*WIDTH*HEIGHT cycles.
- End of generation, cycle after last WRITE:
  - cur_bank toggles; generation increments; gen_done=1 for 1 cycle.
  - Next state: IDLE, or straight into the next generation if run is high at that cycle. clear/load are not sampled between back-to-back generations.
- rd and wr never target the same bank in the same cycle.
- plot is asserted only in LOAD, CLEAR and WRITE-with-change. x, y and colour hold their last values otherwise.

Test Plan:
- Blinker: load (10,10),(11,10),(12,10); start -> exactly 4 plots: (11,9) and (11,11) white, (10,10) and (12,10) black, in raster order. gen_done after 11*19200 cycles; generation=1.
- Block still life: load (0,0),(1,0),(0,1),(1,1); start -> zero plots. Corner reads issue rd_en on 4 slots per corner cell. generation=1.
- run held for 2 gens on blinker -> horizontal phase restored, 8 plots total, generation=2, cur_bank back to 0.
- Busy rejection: load (50,50) mid-generation -> no write or plot to (50,50). load_x=200 in IDLE -> no write, no plot.
- Clear after blinker -> 19200 plots, all colour 0. Then start -> zero plots.
- Reset asserted 500 cycles into a generation -> all outputs 0 the same cycle, busy=0, cur_bank=0, generation=0. A fresh start then runs normally.

Source files
------------

// File: rtl/life_sequencer.sv
// life_sequencer: steps one Conway generation across a double-banked 1-bit cell RAM,
// plotting only the cells that change; also services single-cell loads and full-grid clears.
module life_sequencer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        run,
    input  logic        load,
    input  logic [7:0]  load_x,
    input  logic [6:0]  load_y,
    input  logic        clear,
    output logic        rd_en,
    output logic [7:0]  rd_x,
    output logic [6:0]  rd_y,
    output logic        rd_bank,
    input  logic        rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_x,
    output logic [6:0]  wr_y,
    output logic        wr_bank,
    output logic        wr_data,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        gen_done,
    output logic [15:0] generation
);

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_FETCH,
        S_EVAL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_bank;
    logic [15:0] r_gen;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [1:0]  r_kx;
    logic [1:0]  r_ky;
    logic [3:0]  r_count;
    logic        r_self;
    logic        r_prev_valid;
    logic        r_prev_self;
    logic        r_next;
    logic        r_cur;
    logic [7:0]  r_lx;
    logic [6:0]  r_ly;
    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [2:0]  r_colour;

    logic        w_last_cell;
    logic [7:0]  w_cx_adv;
    logic [6:0]  w_cy_adv;
    logic        w_x_ok;
    logic        w_y_ok;
    logic [7:0]  w_nx;
    logic [6:0]  w_ny;
    logic        w_slot_first;
    logic        w_slot_self;
    logic        w_slot_last;
    logic        w_in_data;
    logic [3:0]  w_count_now;
    logic        w_self_now;
    logic        w_next_now;
    logic        w_load_ok;

    assign w_last_cell = (r_cx == X_LAST) && (r_cy == Y_LAST);
    assign w_cx_adv    = (r_cx == X_LAST) ? 8'd0 : r_cx + 8'd1;
    assign w_cy_adv    = (r_cx == X_LAST) ? ((r_cy == Y_LAST) ? 7'd0 : r_cy + 7'd1) : r_cy;

    // Neighbour slot (kx,ky) in 0..2 maps to offset (kx-1, ky-1); grid edges are dead, no wrap.
    assign w_x_ok = !((r_kx == 2'd0) && (r_cx == 8'd0)) && !((r_kx == 2'd2) && (r_cx == X_LAST));
    assign w_y_ok = !((r_ky == 2'd0) && (r_cy == 7'd0)) && !((r_ky == 2'd2) && (r_cy == Y_LAST));
    assign w_nx   = (r_kx == 2'd0) ? r_cx - 8'd1 : (r_kx == 2'd2) ? r_cx + 8'd1 : r_cx;
    assign w_ny   = (r_ky == 2'd0) ? r_cy - 7'd1 : (r_ky == 2'd2) ? r_cy + 7'd1 : r_cy;

    assign w_slot_first = (r_kx == 2'd0) && (r_ky == 2'd0);
    assign w_slot_self  = (r_kx == 2'd1) && (r_ky == 2'd1);
    assign w_slot_last  = (r_kx == 2'd2) && (r_ky == 2'd2);

    // rd_data belongs to the slot issued on the previous cycle.
    assign w_in_data   = r_prev_valid & rd_data;
    assign w_count_now = r_count + {3'b000, w_in_data & ~r_prev_self};
    assign w_self_now  = r_self | (w_in_data & r_prev_self);
    assign w_next_now  = (w_count_now == 4'd3) | (w_self_now & (w_count_now == 4'd2));

    assign w_load_ok  = (r_lx <= X_LAST) && (r_ly <= Y_LAST);
    assign generation = r_gen;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        rd_en        = 1'b0;
        rd_x         = '0;
        rd_y         = '0;
        rd_bank      = 1'b0;
        wr_en        = 1'b0;
        wr_x         = '0;
        wr_y         = '0;
        wr_bank      = 1'b0;
        wr_data      = 1'b0;
        plot         = 1'b0;
        x            = r_x;
        y            = r_y;
        colour       = r_colour;
        gen_done     = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_state_next = S_CLEAR;
                end else if (load) begin
                    w_state_next = S_LOAD;
                end else if (start || run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_LOAD: begin
                if (w_load_ok) begin
                    wr_en   = 1'b1;
                    wr_x    = r_lx;
                    wr_y    = r_ly;
                    wr_bank = r_bank;
                    wr_data = 1'b1;
                    plot    = 1'b1;
                    x       = r_lx;
                    y       = r_ly;
                    colour  = 3'b111;
                end
                w_state_next = S_IDLE;
            end
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_x    = r_cx;
                wr_y    = r_cy;
                wr_bank = r_bank;
                wr_data = 1'b0;
                plot    = 1'b1;
                x       = r_cx;
                y       = r_cy;
                colour  = 3'b000;
                if (w_last_cell) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                if (w_x_ok && w_y_ok) begin
                    rd_en   = 1'b1;
                    rd_x    = w_nx;
                    rd_y    = w_ny;
                    rd_bank = r_bank;
                end
                if (w_slot_last) begin
                    w_state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                w_state_next = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_x    = r_cx;
                wr_y    = r_cy;
                wr_bank = ~r_bank;
                wr_data = r_next;
                if (r_next != r_cur) begin
                    plot   = 1'b1;
                    x      = r_cx;
                    y      = r_cy;
                    colour = r_next ? 3'b111 : 3'b000;
                end
                w_state_next = w_last_cell ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                gen_done     = 1'b1;
                w_state_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bank       <= 1'b0;
            r_gen        <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_kx         <= '0;
            r_ky         <= '0;
            r_count      <= '0;
            r_self       <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_self  <= 1'b0;
            r_next       <= 1'b0;
            r_cur        <= 1'b0;
            r_lx         <= '0;
            r_ly         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_colour     <= '0;
        end else begin
            r_prev_valid <= 1'b0;
            r_prev_self  <= 1'b0;
            if (plot) begin
                r_x      <= x;
                r_y      <= y;
                r_colour <= colour;
            end
            case (r_state)
                S_IDLE: begin
                    r_cx <= '0;
                    r_cy <= '0;
                    r_kx <= '0;
                    r_ky <= '0;
                    if (load) begin
                        r_lx <= load_x;
                        r_ly <= load_y;
                    end
                end
                S_CLEAR, S_WRITE: begin
                    r_cx <= w_cx_adv;
                    r_cy <= w_cy_adv;
                end
                S_FETCH: begin
                    r_prev_valid <= rd_en;
                    r_prev_self  <= w_slot_self;
                    r_count      <= w_slot_first ? 4'd0 : w_count_now;
                    r_self       <= w_slot_first ? 1'b0 : w_self_now;
                    if (r_kx == 2'd2) begin
                        r_kx <= 2'd0;
                        r_ky <= (r_ky == 2'd2) ? 2'd0 : r_ky + 2'd1;
                    end else begin
                        r_kx <= r_kx + 2'd1;
                    end
                end
                S_EVAL: begin
                    r_next <= w_next_now;
                    r_cur  <= w_self_now;
                end
                S_DONE: begin
                    r_bank <= ~r_bank;
                    r_gen  <= r_gen + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// tb_life_sequencer: drives loads, clears and generations on a small grid against a bench
// cell RAM; expected plots are queued from a reference Life model and matched in order.
module tb_life_sequencer;

    localparam int W = 16;
    localparam int H = 12;
    localparam int N = W * H;
    localparam logic [17:0] NO_EXP = '1;

    logic        clock;
    logic        reset;
    logic        start;
    logic        run;
    logic        load;
    logic [7:0]  load_x;
    logic [6:0]  load_y;
    logic        clear;
    logic        rd_en;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic        rd_bank;
    logic        rd_data;
    logic        wr_en;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic        wr_bank;
    logic        wr_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        gen_done;
    logic [15:0] generation;

    int n_tests = 0;
    int n_fail  = 0;
    int plot_cnt = 0;
    int exp_gen = 0;
    int exp_bank = 0;

    bit mem   [2][W][H];
    bit model [W][H];
    logic [17:0] sb [$];

    life_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start), .run(run),
        .load(load), .load_x(load_x), .load_y(load_y), .clear(clear),
        .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_bank(rd_bank), .rd_data(rd_data),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_bank(wr_bank), .wr_data(wr_data),
        .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .gen_done(gen_done), .generation(generation)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Cell RAM: one-cycle read latency, garbage when no read was issued.
    always @(posedge clock) begin
        if (rd_en && rd_x < W && rd_y < H) begin
            rd_data <= mem[int'(rd_bank)][int'(rd_x)][int'(rd_y)];
        end else begin
            rd_data <= 1'($urandom);
        end
        if (wr_en && wr_x < W && wr_y < H) begin
            mem[int'(wr_bank)][int'(wr_x)][int'(wr_y)] <= wr_data;
        end
    end

    always @(negedge clock) begin
        logic [17:0] exp_p;
        if (!reset) begin
            if (plot) begin
                plot_cnt++;
                if (sb.size() > 0) exp_p = sb.pop_front();
                else exp_p = NO_EXP;
                check("plot", 32'({x, y, colour}), 32'(exp_p));
            end
            if (rd_en && wr_en) check("bank_sep", 32'(rd_bank), 32'(~wr_bank));
        end
    end

    function automatic int step_model();
        bit nxt [W][H];
        int n;
        int c = 0;
        for (int yy = 0; yy < H; yy++) begin
            for (int xx = 0; xx < W; xx++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if ((dx != 0 || dy != 0) && xx + dx >= 0 && xx + dx < W &&
                            yy + dy >= 0 && yy + dy < H) begin
                            n += int'(model[xx + dx][yy + dy]);
                        end
                    end
                end
                nxt[xx][yy] = (n == 3) || (model[xx][yy] && n == 2);
                if (nxt[xx][yy] != model[xx][yy]) begin
                    sb.push_back({8'(xx), 7'(yy), nxt[xx][yy] ? 3'b111 : 3'b000});
                    c++;
                end
            end
        end
        model = nxt;
        return c;
    endfunction

    function automatic int grid_errs(input int b);
        int e = 0;
        for (int xx = 0; xx < W; xx++)
            for (int yy = 0; yy < H; yy++)
                if (mem[b][xx][yy] != model[xx][yy]) e++;
        return e;
    endfunction

    task automatic do_load(input int lx, input int ly);
        bit ok;
        ok = (lx < W) && (ly < H);
        @(negedge clock);
        load = 1'b1;
        load_x = 8'(lx);
        load_y = 7'(ly);
        if (ok) begin
            sb.push_back({8'(lx), 7'(ly), 3'b111});
            model[lx][ly] = 1'b1;
        end
        @(negedge clock);
        load = 1'b0;
        check("load_wr_en", 32'(wr_en), 32'(ok));
        if (ok) check("load_wr_bank", 32'(wr_bank), 32'(exp_bank));
        @(negedge clock);
        check("load_idle", 32'(busy), 32'd0);
        $display("[TB] load (%0d,%0d) accepted=%0d", lx, ly, ok);
    endtask

    task automatic do_clear();
        int cyc;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                sb.push_back({8'(xx), 7'(yy), 3'b000});
                model[xx][yy] = 1'b0;
            end
        @(negedge clock);
        clear = 1'b1;
        cyc = 0;
        while (1) begin
            @(negedge clock);
            clear = 1'b0;
            if (!busy || cyc > N + 20) break;
            cyc++;
        end
        check("clear_cycles", 32'(cyc), 32'(N));
        check("clear_grid", 32'(grid_errs(exp_bank)), 32'd0);
        check("clear_gen", 32'(generation), 32'(exp_gen));
        check("clear_sb", 32'(sb.size()), 32'd0);
        $display("[TB] clear done in %0d cycles", cyc);
    endtask

    task automatic run_gen(input bit use_run, input int n_gens, input bit inject);
        int cyc, rds, first, exp_cnt, plots0;
        exp_cnt = 0;
        for (int g = 0; g < n_gens; g++) exp_cnt += step_model();
        plots0 = plot_cnt;
        @(negedge clock);
        if (use_run) run = 1'b1;
        else start = 1'b1;
        for (int g = 0; g < n_gens; g++) begin
            cyc = 0;
            rds = 0;
            first = 0;
            while (1) begin
                @(negedge clock);
                cyc++;
                start = 1'b0;
                if (g == n_gens - 1 && cyc == 2) run = 1'b0;
                if (rd_en) rds++;
                if (cyc <= 9 && rd_en) first++;
                if (cyc == 5) begin
                    check("self_rd_en", 32'(rd_en), 32'd1);
                    check("self_rd_addr", 32'({rd_x, rd_y}), 32'd0);
                    check("rd_bank", 32'(rd_bank), 32'(exp_bank));
                end
                if (inject && cyc == 100) begin
                    check("busy_mid", 32'(busy), 32'd1);
                    load = 1'b1;
                    load_x = 8'd5;
                    load_y = 7'd5;
                    clear = 1'b1;
                end
                if (inject && cyc == 101) begin
                    load = 1'b0;
                    clear = 1'b0;
                end
                if (gen_done || cyc >= 11 * N + 20) break;
            end
            check("gen_latency", 32'(cyc), 32'(11 * N + 1));
            check("rd_total", 32'(rds), 32'((3 * W - 2) * (3 * H - 2)));
            check("corner_rds", 32'(first), 32'd4);
            exp_bank ^= 1;
            exp_gen++;
        end
        @(negedge clock);
        check("gen_pulse", 32'(gen_done), 32'd0);
        check("gen_busy", 32'(busy), 32'd0);
        check("generation", 32'(generation), 32'(exp_gen));
        check("gen_plots", 32'(plot_cnt - plots0), 32'(exp_cnt));
        check("gen_sb", 32'(sb.size()), 32'd0);
        check("gen_grid", 32'(grid_errs(exp_bank)), 32'd0);
        $display("[TB] %0d generation(s) done, plots=%0d, generation=%0d", n_gens, plot_cnt - plots0, generation);
    endtask

    initial begin
        #700000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        run = 1'b0;
        load = 1'b0;
        clear = 1'b0;
        load_x = '0;
        load_y = '0;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gen", 32'(generation), 32'd0);
        check("rst_strobes", 32'({rd_en, wr_en, plot, gen_done}), 32'd0);
        check("rst_pixel", 32'({x, y, colour}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Blinker plus rejected out-of-range loads, then one generation with mid-run requests.
        do_load(10, 10);
        do_load(11, 10);
        do_load(12, 10);
        do_load(200, 3);
        do_load(W, 0);
        do_load(0, H);
        run_gen(1'b0, 1, 1'b1);
        check("busy_load_cell", 32'(mem[exp_bank][5][5]), 32'd0);

        run_gen(1'b1, 2, 1'b0);

        do_clear();
        run_gen(1'b0, 1, 1'b0);

        // Block still life at the corner.
        do_load(0, 0);
        do_load(1, 0);
        do_load(0, 1);
        do_load(1, 1);
        run_gen(1'b0, 1, 1'b0);

        // Reset 500 cycles into a generation.
        @(negedge clock);
        start = 1'b1;
        repeat (500) begin
            @(negedge clock);
            start = 1'b0;
        end
        #1 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_gen", 32'(generation), 32'd0);
        check("arst_strobes", 32'({rd_en, wr_en, plot, gen_done}), 32'd0);
        check("arst_pixel", 32'({x, y, colour}), 32'd0);
        check("arst_addr", 32'({rd_x, rd_y, wr_x, wr_y}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_bank = 0;
        exp_gen = 0;
        for (int xx = 0; xx < W; xx++)
            for (int yy = 0; yy < H; yy++)
                model[xx][yy] = mem[0][xx][yy];
        $display("[TB] reset mid-generation applied");
        do_load(0, 0);
        run_gen(1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
